// File: rtl/regfile_pkg.sv
// +----------------------------------------------------------------------+
// | regfile_pkg: register-file geometry and writeback requester indices. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;
  localparam int REG_COUNT = 8;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 3;
  localparam int REQ_ALU   = 0;
  localparam int REQ_LOAD  = 1;
endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// +----------------------------------------------------------------------+
// | rr_arb2: two-request round-robin grant with last-granted register.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import regfile_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic r_last;

  always_comb begin
    gnt = 2'b00;
    if (!RESET) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Contention goes to whoever was not served most recently.
        2'b11:   gnt = (r_last == 1'b1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_last <= 1'b1;
    end else if (accept) begin
      r_last <= gnt[REQ_LOAD];
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// +----------------------------------------------------------------------+
// | reg_write_arbiter: shares the register-file write port between the  |
// | ALU and load path; tracks pending writes for RAW hazard detection.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ0_VALID,
  input  logic [ADDR_W-1:0]    REQ0_ADDR,
  input  logic [DATA_W-1:0]    REQ0_DATA,
  output logic                 REQ0_READY,
  input  logic                 REQ1_VALID,
  input  logic [ADDR_W-1:0]    REQ1_ADDR,
  input  logic [DATA_W-1:0]    REQ1_DATA,
  output logic                 REQ1_READY,
  output logic                 WRITE,
  output logic [ADDR_W-1:0]    INADDRESS,
  output logic [DATA_W-1:0]    IN,
  input  logic [ADDR_W-1:0]    RD1_ADDR,
  input  logic [ADDR_W-1:0]    RD2_ADDR,
  output logic                 HAZARD1,
  output logic                 HAZARD2,
  output logic [2**ADDR_W-1:0] BUSY
);

  import regfile_pkg::*;

  logic [1:0]          w_gnt;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [2**ADDR_W-1:0] w_busy_nxt;

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RESET  (RESET),
    .req    ({REQ1_VALID, REQ0_VALID}),
    .accept (w_xfer),
    .gnt    (w_gnt)
  );

  assign REQ0_READY = w_gnt[REQ_ALU];
  assign REQ1_READY = w_gnt[REQ_LOAD];
  assign w_xfer     = (REQ0_VALID & REQ0_READY) | (REQ1_VALID & REQ1_READY);
  assign w_addr     = w_gnt[REQ_LOAD] ? REQ1_ADDR : REQ0_ADDR;
  assign w_data     = w_gnt[REQ_LOAD] ? REQ1_DATA : REQ0_DATA;

  // Commit clears first so a back-to-back write to the same register keeps it busy.
  always_comb begin
    w_busy_nxt = BUSY;
    if (WRITE) w_busy_nxt[INADDRESS] = 1'b0;
    if (w_xfer) w_busy_nxt[w_addr] = 1'b1;
  end

  assign HAZARD1 = BUSY[RD1_ADDR] | (w_xfer && (w_addr == RD1_ADDR));
  assign HAZARD2 = BUSY[RD2_ADDR] | (w_xfer && (w_addr == RD2_ADDR));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      WRITE     <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
      BUSY      <= '0;
    end else begin
      WRITE <= w_xfer;
      BUSY  <= w_busy_nxt;
      if (w_xfer) begin
        INADDRESS <= w_addr;
        IN        <= w_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_reg_write_arbiter: directed and randomized bench with a          |
// | transaction-level reference model of the write arbiter.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_write_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic [2:0] REQ0_ADDR = '0, REQ1_ADDR = '0;
  logic [7:0] REQ0_DATA = '0, REQ1_DATA = '0;
  logic       REQ0_READY, REQ1_READY;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic [2:0] RD1_ADDR = '0, RD2_ADDR = '0;
  logic       HAZARD1, HAZARD2;
  logic [7:0] BUSY;

  int checks = 0;
  int errors = 0;

  // Reference model: LAST index, the write currently presented, and the
  // observation that BUSY is exactly the register accepted one cycle ago.
  int         m_last = 1;
  logic       m_write = 1'b0;
  logic [2:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic [7:0] m_busy = '0;
  logic [7:0] mem_obs [8];

  reg_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR),
    .HAZARD1(HAZARD1), .HAZARD2(HAZARD2), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [1:0] m_grant();
    if (RESET) return 2'b00;
    if (REQ0_VALID && REQ1_VALID) return (m_last == 1) ? 2'b01 : 2'b10;
    return {REQ1_VALID, REQ0_VALID};
  endfunction

  function automatic logic m_hazard(input logic [2:0] rd);
    logic [1:0] g;
    logic [2:0] ga;
    g  = m_grant();
    ga = g[1] ? REQ1_ADDR : REQ0_ADDR;
    return m_busy[rd] || ((g != 2'b00) && (ga == rd));
  endfunction

  // Advance one clock, keeping the model and the observed register file in step.
  task automatic tick();
    logic [1:0] g;
    g = m_grant();
    if (RESET) begin
      for (int i = 0; i < 8; i++) mem_obs[i] = 8'h00;
    end else if (WRITE) begin
      mem_obs[INADDRESS] = IN;
    end
    @(posedge CLK);
    if (RESET) begin
      m_last = 1; m_write = 1'b0; m_addr = '0; m_data = '0; m_busy = '0;
    end else if (g != 2'b00) begin
      m_last  = g[1] ? 1 : 0;
      m_write = 1'b1;
      m_addr  = g[1] ? REQ1_ADDR : REQ0_ADDR;
      m_data  = g[1] ? REQ1_DATA : REQ0_DATA;
      m_busy  = 8'h01 << m_addr;
    end else begin
      m_write = 1'b0;
      m_busy  = '0;
    end
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd1; REQ0_DATA = 8'h11;
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd6; REQ1_DATA = 8'h66;
    RD1_ADDR = 3'd1; RD2_ADDR = 3'd6;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({REQ1_READY, REQ0_READY} !== 2'b00) begin
        errors++; $display("FAIL reset_ready: got %b want 00", {REQ1_READY, REQ0_READY});
      end
      tick();
      checks++;
      if (WRITE !== 1'b0 || BUSY !== 8'h00) begin
        errors++; $display("FAIL reset_state: WRITE=%b BUSY=%h want 0/00", WRITE, BUSY);
      end
    end
    RESET = 1'b0; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    #1;
    checks++;
    if ({HAZARD2, HAZARD1, INADDRESS, IN} !== 13'h0) begin
      errors++; $display("FAIL post_reset: HZ=%b%b INADDRESS=%0d IN=%h want 0", HAZARD2, HAZARD1, INADDRESS, IN);
    end
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    #1;
    checks++;
    if ({REQ1_READY, REQ0_READY} !== 2'b01) begin
      errors++; $display("FAIL first_grant: got %b want 01", {REQ1_READY, REQ0_READY});
    end
    tick();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    checks++;
    if ({WRITE, INADDRESS, IN} !== {1'b1, 3'd1, 8'h11}) begin
      errors++; $display("FAIL first_write: got %b/%0d/%h want 1/1/11", WRITE, INADDRESS, IN);
    end
    tick(); tick();
  endtask

  task automatic test_single_write();
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd2; REQ0_DATA = 8'h1F;
    RD1_ADDR = 3'd2; RD2_ADDR = 3'd5;
    #1;
    checks++;
    if ({REQ0_READY, HAZARD1, HAZARD2} !== 3'b110) begin
      errors++; $display("FAIL single_accept: READY0/HZ1/HZ2=%b%b%b want 110", REQ0_READY, HAZARD1, HAZARD2);
    end
    tick();
    REQ0_VALID = 1'b0;
    #1;
    checks++;
    if ({WRITE, INADDRESS, IN, BUSY, HAZARD1} !== {1'b1, 3'd2, 8'h1F, 8'h04, 1'b1}) begin
      errors++; $display("FAIL single_write: got %b/%0d/%h BUSY=%h HZ1=%b want 1/2/1f 04 1",
                         WRITE, INADDRESS, IN, BUSY, HAZARD1);
    end
    tick();
    checks++;
    if ({WRITE, BUSY, HAZARD1} !== {1'b0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL single_commit: WRITE=%b BUSY=%h HZ1=%b want 0 00 0", WRITE, BUSY, HAZARD1);
    end
  endtask

  task automatic test_idle_hold();
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd4; REQ0_DATA = 8'hC3;
    tick();
    REQ0_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({WRITE, INADDRESS, IN} !== {1'b0, 3'd4, 8'hC3}) begin
        errors++; $display("FAIL idle_hold%0d: got %b/%0d/%h want 0/4/c3", i, WRITE, INADDRESS, IN);
      end
    end
    // Last grant was requester 0, so contention must now go to requester 1.
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    #1;
    checks++;
    if ({REQ1_READY, REQ0_READY} !== 2'b10) begin
      errors++; $display("FAIL idle_last: got %b want 10", {REQ1_READY, REQ0_READY});
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic [7:0] obs[$];
    logic [7:0] want;
    int ia = 0, ib = 0;
    logic r0, r1;
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd0; REQ1_DATA = 8'h00;
    tick();
    REQ1_VALID = 1'b0;
    tick();
    REQ0_ADDR = 3'($urandom_range(7, 0));
    REQ1_ADDR = 3'($urandom_range(7, 0));
    for (int cyc = 0; cyc < 14 && obs.size() < 8; cyc++) begin
      REQ0_VALID = (ia < 4); REQ0_DATA = 8'hA0 + 8'(ia);
      REQ1_VALID = (ib < 4); REQ1_DATA = 8'hB0 + 8'(ib);
      #1;
      r0 = REQ0_READY; r1 = REQ1_READY;
      tick();
      if (r0) ia++;
      if (r1) ib++;
      if (WRITE) obs.push_back(IN);
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    checks++;
    if (obs.size() != 8) begin
      errors++; $display("FAIL contention_count: got %0d writes want 8", obs.size());
    end
    for (int k = 0; k < 8 && k < obs.size(); k++) begin
      want = (k % 2 == 0) ? 8'hA0 + 8'(k / 2) : 8'hB0 + 8'(k / 2);
      checks++;
      if (obs[k] !== want) begin
        errors++; $display("FAIL contention_seq%0d: got %h want %h", k, obs[k], want);
      end
    end
    tick();
  endtask

  task automatic test_collision();
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd1; REQ1_DATA = 8'h01;
    tick();
    REQ1_VALID = 1'b0;
    tick();
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd5; REQ0_DATA = 8'h55;
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd5; REQ1_DATA = 8'hAA;
    RD1_ADDR = 3'd5;
    #1;
    checks++;
    if ({REQ1_READY, REQ0_READY} !== 2'b01) begin
      errors++; $display("FAIL collide_grant: got %b want 01", {REQ1_READY, REQ0_READY});
    end
    tick();
    REQ0_VALID = 1'b0;
    #1;
    checks++;
    if ({WRITE, IN, BUSY[5], REQ1_READY} !== {1'b1, 8'h55, 1'b1, 1'b1}) begin
      errors++; $display("FAIL collide_first: got %b/%h BUSY5=%b READY1=%b want 1/55 1 1", WRITE, IN, BUSY[5], REQ1_READY);
    end
    tick();
    REQ1_VALID = 1'b0;
    #1;
    checks++;
    if ({WRITE, IN, BUSY[5], HAZARD1} !== {1'b1, 8'hAA, 1'b1, 1'b1}) begin
      errors++; $display("FAIL collide_second: got %b/%h BUSY5=%b HZ1=%b want 1/aa 1 1", WRITE, IN, BUSY[5], HAZARD1);
    end
    tick();
    checks++;
    if ({BUSY[5], mem_obs[5]} !== {1'b0, 8'hAA}) begin
      errors++; $display("FAIL collide_final: BUSY5=%b reg5=%h want 0 aa", BUSY[5], mem_obs[5]);
    end
  endtask

  task automatic test_reset_midflight();
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd3; REQ0_DATA = 8'h33;
    tick();
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd6; REQ1_DATA = 8'h66;
    RESET = 1'b1;
    #1;
    checks++;
    if ({WRITE, REQ1_READY} !== 2'b10) begin
      errors++; $display("FAIL midreset_pre: WRITE=%b READY1=%b want 1 0", WRITE, REQ1_READY);
    end
    tick();
    checks++;
    if ({WRITE, BUSY, REQ1_READY} !== {1'b0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL midreset_drop: WRITE=%b BUSY=%h READY1=%b want 0 00 0", WRITE, BUSY, REQ1_READY);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (REQ1_READY !== 1'b1) begin
      errors++; $display("FAIL midreset_release: READY1=%b want 1", REQ1_READY);
    end
    tick();
    REQ1_VALID = 1'b0;
    checks++;
    if ({WRITE, INADDRESS, IN} !== {1'b1, 3'd6, 8'h66}) begin
      errors++; $display("FAIL midreset_write: got %b/%0d/%h want 1/6/66", WRITE, INADDRESS, IN);
    end
    tick();
  endtask

  task automatic test_random();
    logic r0, r1;
    for (int n = 0; n < 400; n++) begin
      if (!REQ0_VALID && $urandom_range(1, 0) == 1) begin
        REQ0_VALID = 1'b1; REQ0_ADDR = 3'($urandom); REQ0_DATA = 8'($urandom);
      end else if (REQ0_VALID && $urandom_range(15, 0) == 0) begin
        REQ0_VALID = 1'b0;
      end
      if (!REQ1_VALID && $urandom_range(1, 0) == 1) begin
        REQ1_VALID = 1'b1; REQ1_ADDR = 3'($urandom); REQ1_DATA = 8'($urandom);
      end else if (REQ1_VALID && $urandom_range(15, 0) == 0) begin
        REQ1_VALID = 1'b0;
      end
      RESET    = ($urandom_range(49, 0) == 0);
      RD1_ADDR = 3'($urandom);
      RD2_ADDR = 3'($urandom);
      #1;
      checks++;
      if ({REQ1_READY, REQ0_READY, HAZARD2, HAZARD1} !==
          {m_grant(), m_hazard(RD2_ADDR), m_hazard(RD1_ADDR)}) begin
        errors++; $display("FAIL rand_comb%0d: READY=%b%b HZ=%b%b want %b %b%b", n, REQ1_READY, REQ0_READY,
                           HAZARD2, HAZARD1, m_grant(), m_hazard(RD2_ADDR), m_hazard(RD1_ADDR));
      end
      r0 = REQ0_READY; r1 = REQ1_READY;
      tick();
      if (r0) REQ0_VALID = 1'b0;
      if (r1) REQ1_VALID = 1'b0;
      checks++;
      if ({WRITE, INADDRESS, IN, BUSY} !== {m_write, m_addr, m_data, m_busy}) begin
        errors++; $display("FAIL rand_regs%0d: got %b/%0d/%h BUSY=%h want %b/%0d/%h BUSY=%h", n,
                           WRITE, INADDRESS, IN, BUSY, m_write, m_addr, m_data, m_busy);
      end
    end
    RESET = 1'b0; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_obs[i] = 8'h00;
    test_reset();
    test_single_write();
    test_idle_hold();
    test_contention();
    test_collision();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
